// File: rtl/regfile_wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared constants, FSM state type and grant-priority helper for
//               the register-bank writeback arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

  localparam int NUM_WB_REQ = 3;
  localparam int REQ_LNK    = 0;   // highest fixed priority
  localparam int REQ_LD     = 1;
  localparam int REQ_ALU    = 2;   // lowest fixed priority
  localparam logic [4:0] LINK_REG = 5'd31;
  localparam int NUM_REGS   = 32;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    DUMP = 1'b1
  } wb_state_t;

  // Lower index means higher fixed priority. If any requester is starved,
  // only the starved set competes; ties inside it still follow fixed order.
  function automatic logic [NUM_WB_REQ-1:0] pick_grant(
    input logic [NUM_WB_REQ-1:0] req,
    input logic [NUM_WB_REQ-1:0] starved
  );
    logic [NUM_WB_REQ-1:0] pool;
    pick_grant = '0;
    pool = (|starved) ? starved : req;
    for (int i = NUM_WB_REQ - 1; i >= 0; i--) begin
      if (pool[i]) begin
        pick_grant    = '0;
        pick_grant[i] = 1'b1;
      end
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter_if
// Description : Requester handshakes, bank write port and (with
//               REGFILE_DUMP_EN defined) the register-dump signals.
//               master = pipeline/bank side, slave = arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              pause;
  logic              alu_req;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              alu_gnt;
  logic              ld_req;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_gnt;
  logic              lnk_req;
  logic [DATA_W-1:0] lnk_pc;
  logic              lnk_gnt;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              wb_busy;
`ifdef REGFILE_DUMP_EN
  logic              dump_start;
  logic [ADDR_W-1:0] rf_raddr;
  logic [DATA_W-1:0] dump_rdata;
  logic              dump_valid;
  logic [ADDR_W-1:0] dump_idx;
  logic [DATA_W-1:0] dump_data;

  modport master (
    output pause, alu_req, alu_addr, alu_data, ld_req, ld_addr, ld_data,
           lnk_req, lnk_pc, dump_start, dump_rdata,
    input  alu_gnt, ld_gnt, lnk_gnt, rf_we, rf_waddr, rf_wdata, wb_busy,
           rf_raddr, dump_valid, dump_idx, dump_data
  );

  modport slave (
    input  pause, alu_req, alu_addr, alu_data, ld_req, ld_addr, ld_data,
           lnk_req, lnk_pc, dump_start, dump_rdata,
    output alu_gnt, ld_gnt, lnk_gnt, rf_we, rf_waddr, rf_wdata, wb_busy,
           rf_raddr, dump_valid, dump_idx, dump_data
  );
`else
  modport master (
    output pause, alu_req, alu_addr, alu_data, ld_req, ld_addr, ld_data,
           lnk_req, lnk_pc,
    input  alu_gnt, ld_gnt, lnk_gnt, rf_we, rf_waddr, rf_wdata, wb_busy
  );

  modport slave (
    input  pause, alu_req, alu_addr, alu_data, ld_req, ld_addr, ld_data,
           lnk_req, lnk_pc,
    output alu_gnt, ld_gnt, lnk_gnt, rf_we, rf_waddr, rf_wdata, wb_busy
  );
`endif
endinterface
`default_nettype wire

// File: rtl/regfile_wb_arbiter_age.sv
`default_nettype none
// ============================================================================
// Module      : wb_age_counter
// Description : Per-requester wait counter. Counts cycles a request is
//               pending and not granted, saturating at STARVE_LIMIT; flags
//               starved at saturation. Holds while hold=1.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_age_counter #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic gnt,
  input  logic hold,
  output logic starved
);
  localparam int              CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] count_q, count_d;

  // Next count: a dropped or granted request restarts aging from zero.
  always_comb begin
    count_d = count_q;
    if (!req || gnt) begin
      count_d = '0;
    end else if (!hold && (count_q != C_LIMIT)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign starved = (count_q == C_LIMIT);

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Shares the register-bank write port between link, load and
//               ALU writebacks (fixed priority with aging). Combinational
//               one-cycle grants, registered bank write one cycle later.
//               Optional macro REGFILE_DUMP_EN adds a 32-entry register dump
//               over bank read port 1 while paused.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int STARVE_LIMIT = 8,
  parameter int ZERO_REG_RO  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_wb_arbiter_if.slave  bus
);

  logic [NUM_WB_REQ-1:0] req_vec;
  logic [NUM_WB_REQ-1:0] starved_vec;
  logic [NUM_WB_REQ-1:0] gnt_vec;
  logic                  dump_active;
  logic                  grant_en;
  logic                  age_hold;

  logic [ADDR_W-1:0]     sel_addr;
  logic [DATA_W-1:0]     sel_data;

  logic                  rf_we_q,    rf_we_d;
  logic [ADDR_W-1:0]     rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0]     rf_wdata_q, rf_wdata_d;

  assign req_vec[REQ_LNK] = bus.lnk_req;
  assign req_vec[REQ_LD]  = bus.ld_req;
  assign req_vec[REQ_ALU] = bus.alu_req;

  // Aging is frozen whenever grants are blocked by pause or a dump.
  assign age_hold = bus.pause | dump_active;

  generate
    for (genvar i = 0; i < NUM_WB_REQ; i++) begin : g_age
      wb_age_counter #(
        .STARVE_LIMIT (STARVE_LIMIT)
      ) u_age (
        .clk     (clk),
        .reset   (reset),
        .req     (req_vec[i]),
        .gnt     (gnt_vec[i]),
        .hold    (age_hold),
        .starved (starved_vec[i])
      );
    end
  endgenerate

  assign grant_en = !bus.pause && !dump_active;
  assign gnt_vec  = grant_en ? pick_grant(req_vec, req_vec & starved_vec) : '0;

  assign bus.lnk_gnt = gnt_vec[REQ_LNK];
  assign bus.ld_gnt  = gnt_vec[REQ_LD];
  assign bus.alu_gnt = gnt_vec[REQ_ALU];
  assign bus.wb_busy = |(req_vec & ~gnt_vec);

  // Payload of the granted requester; link writes pc+1 into the link register.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    if (gnt_vec[REQ_LNK]) begin
      sel_addr = ADDR_W'(LINK_REG);
      sel_data = bus.lnk_pc + DATA_W'(1);
    end else if (gnt_vec[REQ_LD]) begin
      sel_addr = bus.ld_addr;
      sel_data = bus.ld_data;
    end else if (gnt_vec[REQ_ALU]) begin
      sel_addr = bus.alu_addr;
      sel_data = bus.alu_data;
    end
  end

  // Next bank write: a granted r0 write is consumed but suppressed when r0 is read-only.
  always_comb begin
    rf_we_d    = (|gnt_vec) && !((ZERO_REG_RO != 0) && (sel_addr == '0));
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (|gnt_vec) begin
      rf_waddr_d = sel_addr;
      rf_wdata_d = sel_data;
    end
  end

  // Bank write port registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign bus.rf_we    = rf_we_q;
  assign bus.rf_waddr = rf_waddr_q;
  assign bus.rf_wdata = rf_wdata_q;

`ifdef REGFILE_DUMP_EN
  wb_state_t         state_q;
  logic [ADDR_W-1:0] idx_q;

  // Dump sequencer: starts only from IDLE while paused, walks idx 0..31 once.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.dump_start && bus.pause) begin
            state_q <= DUMP;
            idx_q   <= '0;
          end
        end
        DUMP: begin
          if (idx_q == ADDR_W'(NUM_REGS - 1)) begin
            state_q <= IDLE;
            idx_q   <= '0;
          end else begin
            idx_q   <= idx_q + ADDR_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          idx_q   <= '0;
        end
      endcase
    end
  end

  assign dump_active    = (state_q == DUMP);
  assign bus.rf_raddr   = dump_active ? idx_q : '0;
  assign bus.dump_valid = dump_active;
  assign bus.dump_idx   = idx_q;
  assign bus.dump_data  = dump_active ? bus.dump_rdata : '0;
`else
  assign dump_active = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Self-checking bench for regfile_wb_arbiter: directed
//               scenarios plus randomized traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int LIMIT = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  regfile_wb_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  regfile_wb_arbiter #(
    .DATA_W       (DW),
    .ADDR_W       (AW),
    .STARVE_LIMIT (LIMIT),
    .ZERO_REG_RO  (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

`ifdef REGFILE_DUMP_EN
  logic [DW-1:0] tb_bank [32];
  assign bus.dump_rdata = tb_bank[bus.rf_raddr];
`endif

  task automatic set_idle();
    bus.pause    = 1'b0;
    bus.alu_req  = 1'b0; bus.alu_addr = '0; bus.alu_data = '0;
    bus.ld_req   = 1'b0; bus.ld_addr  = '0; bus.ld_data  = '0;
    bus.lnk_req  = 1'b0; bus.lnk_pc   = '0;
`ifdef REGFILE_DUMP_EN
    bus.dump_start = 1'b0;
`endif
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      set_idle();
    end
  endtask

  task automatic test_reset();
    logic [2:0] g;
    set_idle();
    reset = 1'b1;
    idle_cycles(3);
    reset = 1'b0;
    @(negedge clk);
    g = {bus.lnk_gnt, bus.ld_gnt, bus.alu_gnt};
    n_cmp++;
    if ({g, bus.rf_we, bus.wb_busy} !== 5'b0) begin
      n_err++; $display("FAIL reset_ctrl got gnt=%b we=%b busy=%b exp all 0", g, bus.rf_we, bus.wb_busy);
    end
    n_cmp++;
    if ({bus.rf_waddr, bus.rf_wdata} !== '0) begin
      n_err++; $display("FAIL reset_payload got %h/%h exp 0/0", bus.rf_waddr, bus.rf_wdata);
    end
    // A grant followed by reset must leave nothing behind.
    @(posedge clk); #1;
    bus.ld_req = 1'b1; bus.ld_addr = 5'd9; bus.ld_data = 32'hBEEF;
    @(posedge clk); #1;
    set_idle(); reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== '0) begin
      n_err++; $display("FAIL reset_abort got we=%b %h/%h exp 0", bus.rf_we, bus.rf_waddr, bus.rf_wdata);
    end
  endtask

  task automatic test_single_load();
    idle_cycles(2);
    @(posedge clk); #1;
    bus.ld_req = 1'b1; bus.ld_addr = 5'd5; bus.ld_data = 32'h1234;
    @(negedge clk);
    n_cmp++;
    if ({bus.lnk_gnt, bus.ld_gnt, bus.alu_gnt, bus.wb_busy} !== 4'b0100) begin
      n_err++; $display("FAIL single_gnt got %b%b%b busy=%b exp 010 busy=0", bus.lnk_gnt, bus.ld_gnt, bus.alu_gnt, bus.wb_busy);
    end
    @(posedge clk); #1;
    set_idle();
    @(negedge clk);
    n_cmp++;
    if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 5'd5, 32'h1234}) begin
      n_err++; $display("FAIL single_write got %b %h %h exp 1 05 00001234", bus.rf_we, bus.rf_waddr, bus.rf_wdata);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (bus.rf_we !== 1'b0) begin
      n_err++; $display("FAIL single_we_drop got %b exp 0", bus.rf_we);
    end
  endtask

  task automatic test_all_three();
    logic [2:0]    exp_g [4];
    logic [37:0]   exp_w [4];
    exp_g = '{3'b100, 3'b010, 3'b001, 3'b000};
    exp_w = '{38'h0, {1'b1, 5'd31, 32'h41}, {1'b1, 5'd3, 32'h333}, {1'b1, 5'd4, 32'h444}};
    idle_cycles(2);
    @(posedge clk); #1;
    bus.lnk_req = 1'b1; bus.lnk_pc = 32'h40;
    bus.ld_req  = 1'b1; bus.ld_addr = 5'd3; bus.ld_data = 32'h333;
    bus.alu_req = 1'b1; bus.alu_addr = 5'd4; bus.alu_data = 32'h444;
    for (int c = 0; c < 4; c++) begin
      if (c == 1) begin @(posedge clk); #1; bus.lnk_req = 1'b0; end
      if (c == 2) begin @(posedge clk); #1; bus.ld_req  = 1'b0; end
      if (c == 3) begin @(posedge clk); #1; bus.alu_req = 1'b0; end
      @(negedge clk);
      n_cmp++;
      if ({bus.lnk_gnt, bus.ld_gnt, bus.alu_gnt} !== exp_g[c]) begin
        n_err++; $display("FAIL order_gnt[%0d] got %b exp %b", c, {bus.lnk_gnt, bus.ld_gnt, bus.alu_gnt}, exp_g[c]);
      end
      if (c > 0) begin
        n_cmp++;
        if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== exp_w[c]) begin
          n_err++; $display("FAIL order_write[%0d] got %h exp %h", c, {bus.rf_we, bus.rf_waddr, bus.rf_wdata}, exp_w[c]);
        end
      end
    end
  endtask

  task automatic test_starvation();
    bit done = 1'b0;
    int when = -1;
    idle_cycles(2);
    for (int c = 0; c < 20 && !done; c++) begin
      @(posedge clk); #1;
      bus.lnk_req = 1'b1; bus.lnk_pc  = 32'(c);
      bus.ld_req  = 1'b1; bus.ld_addr = 5'd2; bus.ld_data = 32'(c + 100);
      bus.alu_req = 1'b1; bus.alu_addr = 5'd6; bus.alu_data = 32'hA1;
      @(negedge clk);
      if (bus.alu_gnt === 1'b1) begin
        done = 1'b1;
        when = c;
      end
    end
    n_cmp++;
    if (!done || when > 9) begin
      n_err++; $display("FAIL starve_alu got grant at cycle %0d exp <= 9", when);
    end
    idle_cycles(2);
  endtask

  task automatic test_pause();
    idle_cycles(2);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      bus.pause = 1'b1;
      bus.alu_req = 1'b1; bus.alu_addr = 5'd7; bus.alu_data = 32'hCAFE0007;
      @(negedge clk);
      n_cmp++;
      if ({bus.lnk_gnt, bus.ld_gnt, bus.alu_gnt, bus.rf_we, bus.wb_busy} !== 5'b00001) begin
        n_err++; $display("FAIL pause[%0d] got gnt=%b%b%b we=%b busy=%b exp 000 0 1", c, bus.lnk_gnt, bus.ld_gnt, bus.alu_gnt, bus.rf_we, bus.wb_busy);
      end
    end
    @(posedge clk); #1;
    bus.pause = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.alu_gnt, bus.wb_busy} !== 2'b10) begin
      n_err++; $display("FAIL pause_resume got gnt=%b busy=%b exp 1 0", bus.alu_gnt, bus.wb_busy);
    end
    @(posedge clk); #1;
    set_idle();
    @(negedge clk);
    n_cmp++;
    if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 5'd7, 32'hCAFE0007}) begin
      n_err++; $display("FAIL pause_write got %b %h %h exp 1 07 cafe0007", bus.rf_we, bus.rf_waddr, bus.rf_wdata);
    end
  endtask

  task automatic test_zero_and_wrap();
    idle_cycles(2);
    @(posedge clk); #1;
    bus.alu_req = 1'b1; bus.alu_addr = 5'd0; bus.alu_data = 32'hDEAD;
    @(negedge clk);
    n_cmp++;
    if (bus.alu_gnt !== 1'b1) begin
      n_err++; $display("FAIL r0_gnt got %b exp 1", bus.alu_gnt);
    end
    @(posedge clk); #1;
    set_idle();
    bus.lnk_req = 1'b1; bus.lnk_pc = 32'hFFFF_FFFF;
    @(negedge clk);
    n_cmp++;
    if ({bus.rf_we, bus.lnk_gnt} !== 2'b01) begin
      n_err++; $display("FAIL r0_suppress got we=%b lnk_gnt=%b exp 0 1", bus.rf_we, bus.lnk_gnt);
    end
    @(posedge clk); #1;
    set_idle();
    @(negedge clk);
    n_cmp++;
    if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 5'd31, 32'h0}) begin
      n_err++; $display("FAIL link_wrap got %b %h %h exp 1 1f 00000000", bus.rf_we, bus.rf_waddr, bus.rf_wdata);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] prev;
    idle_cycles(2);
    prev = '0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      bus.ld_req = (c < 3); bus.ld_addr = 5'(c + 10); bus.ld_data = 32'h5000 + 32'(c);
      @(negedge clk);
      n_cmp++;
      if (bus.ld_gnt !== (c < 3)) begin
        n_err++; $display("FAIL b2b_gnt[%0d] got %b exp %b", c, bus.ld_gnt, (c < 3));
      end
      if (c > 0) begin
        n_cmp++;
        if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 5'(c + 9), prev}) begin
          n_err++; $display("FAIL b2b_write[%0d] got %b %h %h exp 1 %h %h", c, bus.rf_we, bus.rf_waddr, bus.rf_wdata, 5'(c + 9), prev);
        end
      end
      prev = 32'h5000 + 32'(c);
    end
    idle_cycles(1);
  endtask

  // Randomized traffic: each requester holds its payload until granted, may
  // reissue the next cycle; model tracks per-requester wait cycles.
  task automatic test_random();
    bit [2:0]    pend;
    logic [4:0]  a [3];
    logic [31:0] d [3];
    int          wait_c [3];
    bit          pz, exp_we;
    logic [4:0]  exp_a;
    logic [31:0] exp_d;
    bit [2:0]    pool, exp_gm;
    int          g;
    idle_cycles(2);
    pend = '0; exp_we = 1'b0; exp_a = '0; exp_d = '0;
    for (int i = 0; i < 3; i++) begin wait_c[i] = 0; a[i] = '0; d[i] = '0; end
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        if (!pend[i] && ($urandom_range(1, 0) == 1)) begin
          pend[i] = 1'b1;
          a[i] = ($urandom_range(5, 0) == 0) ? 5'd0 : 5'($urandom);
          d[i] = ($urandom_range(7, 0) == 0) ? 32'hFFFF_FFFF : $urandom;
        end
      end
      pz = ($urandom_range(6, 0) == 0);
      bus.pause   = pz;
      bus.lnk_req = pend[0]; bus.lnk_pc = d[0];
      bus.ld_req  = pend[1]; bus.ld_addr = a[1]; bus.ld_data = d[1];
      bus.alu_req = pend[2]; bus.alu_addr = a[2]; bus.alu_data = d[2];
      g = -1;
      if (!pz) begin
        pool = '0;
        for (int i = 0; i < 3; i++) if (pend[i] && wait_c[i] >= LIMIT) pool[i] = 1'b1;
        if (pool == '0) pool = pend;
        for (int i = 2; i >= 0; i--) if (pool[i]) g = i;
      end
      exp_gm = '0;
      if (g >= 0) exp_gm[g] = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({bus.alu_gnt, bus.ld_gnt, bus.lnk_gnt, bus.wb_busy} !== {exp_gm, |(pend & ~exp_gm)}) begin
        n_err++; $display("FAIL rnd_gnt[%0d] got alu/ld/lnk=%b%b%b busy=%b exp %b busy=%b", c, bus.alu_gnt, bus.ld_gnt, bus.lnk_gnt, bus.wb_busy, exp_gm, |(pend & ~exp_gm));
      end
      n_cmp++;
      if (bus.rf_we !== exp_we || (exp_we && (bus.rf_waddr !== exp_a || bus.rf_wdata !== exp_d))) begin
        n_err++; $display("FAIL rnd_write[%0d] got %b %h %h exp %b %h %h", c, bus.rf_we, bus.rf_waddr, bus.rf_wdata, exp_we, exp_a, exp_d);
      end
      for (int i = 0; i < 3; i++) begin
        if (!pend[i] || i == g) wait_c[i] = 0;
        else if (!pz && wait_c[i] < LIMIT) wait_c[i]++;
      end
      exp_we = 1'b0;
      if (g >= 0) begin
        exp_a  = (g == 0) ? 5'd31 : a[g];
        exp_d  = (g == 0) ? d[0] + 32'd1 : d[g];
        exp_we = (exp_a != 5'd0);
        pend[g] = 1'b0;
      end
    end
    idle_cycles(2);
  endtask

`ifdef REGFILE_DUMP_EN
  task automatic test_dump();
    idle_cycles(2);
    for (int i = 0; i < 32; i++) tb_bank[i] = $urandom;
    @(posedge clk); #1;
    bus.pause = 1'b1; bus.dump_start = 1'b1;
    bus.alu_req = 1'b1; bus.alu_addr = 5'd3; bus.alu_data = 32'h77;
    @(negedge clk);
    for (int k = 0; k < 32; k++) begin
      @(posedge clk); #1;
      bus.dump_start = (k == 5);
      if (k == 16) bus.pause = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({bus.dump_valid, bus.dump_idx, bus.rf_raddr, bus.alu_gnt} !== {1'b1, 5'(k), 5'(k), 1'b0} ||
          bus.dump_data !== tb_bank[k]) begin
        n_err++; $display("FAIL dump[%0d] got v=%b idx=%0d ra=%0d gnt=%b data=%h exp 1 %0d %0d 0 %h", k, bus.dump_valid, bus.dump_idx, bus.rf_raddr, bus.alu_gnt, bus.dump_data, k, k, tb_bank[k]);
      end
    end
    @(posedge clk); #1;
    bus.dump_start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.dump_valid, bus.rf_raddr, bus.alu_gnt} !== {1'b0, 5'd0, 1'b1}) begin
      n_err++; $display("FAIL dump_end got v=%b ra=%0d gnt=%b exp 0 0 1", bus.dump_valid, bus.rf_raddr, bus.alu_gnt);
    end
    idle_cycles(2);
    @(posedge clk); #1;
    bus.pause = 1'b1; bus.dump_start = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      @(posedge clk); #1;
      bus.dump_start = 1'b0;
      if (k == 10) reset = 1'b1;
    end
    @(negedge clk);
    n_cmp++;
    if (bus.dump_idx !== 5'd10) begin
      n_err++; $display("FAIL dump_idx10 got %0d exp 10", bus.dump_idx);
    end
    @(posedge clk); #1;
    reset = 1'b0; set_idle();
    @(negedge clk);
    n_cmp++;
    if (bus.dump_valid !== 1'b0) begin
      n_err++; $display("FAIL dump_reset got v=%b exp 0", bus.dump_valid);
    end
    idle_cycles(2);
  endtask
`endif

  initial begin
    set_idle();
    test_reset();
    test_single_load();
    test_all_three();
    test_starvation();
    test_pause();
    test_zero_and_wrap();
    test_back_to_back();
    test_random();
`ifdef REGFILE_DUMP_EN
    test_dump();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
